// File: rtl/fetch_decode_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction buffer.
// Entries carry the fetched PC, PC+4, instruction word and a misalignment flag.
package fetch_decode_queue_pkg;

  localparam int FQ_XLEN = 32;
  localparam logic [FQ_XLEN-1:0] RV_NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] pc4;
    logic [FQ_XLEN-1:0] instr;
    logic               misalign;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [FQ_XLEN-1:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/fetch_decode_queue_ctrl.sv
// Pointer/occupancy control for the fetch queue: push/pop/flush arbitration.
// Handshake: a beat transfers on a side only in the cycle its valid and ready are both high.
module fetch_queue_ctrl #(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_push_req,
  input  logic          i_pop_req,
  output logic          o_push,
  output logic          o_pop,
  output logic          o_in_ready,
  output logic          o_out_valid,
  output logic [PW-1:0] o_rd_ptr,
  output logic [PW-1:0] o_wr_ptr,
  output logic [CW-1:0] o_count
);

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  assign o_in_ready  = (r_count != CW'(DEPTH));
  assign o_out_valid = (r_count != '0) & ~i_flush;
  assign o_push      = i_push_req & o_in_ready & ~i_flush;
  assign o_pop       = o_out_valid & i_pop_req;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (o_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (o_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({o_push, o_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_ptr = r_rd_ptr;
  assign o_wr_ptr = r_wr_ptr;
  assign o_count  = r_count;

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction buffer between fetch and decode with first-word fall-through,
// flush on redirect, and a canonical NOP presented whenever the head is not valid.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = FQ_XLEN,  // entry layout is fixed at FQ_XLEN
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [XLEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc4,
  output logic [XLEN-1:0] out_instr,
  output logic            out_misalign,
  output logic [CW-1:0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  fetch_entry_t  w_head;
  fetch_entry_t  w_new;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_rd_ptr;
  logic [PW-1:0] w_wr_ptr;

  fetch_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (flush),
    .i_push_req  (in_valid),
    .i_pop_req   (out_ready),
    .o_push      (w_push),
    .o_pop       (w_pop),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_rd_ptr    (w_rd_ptr),
    .o_wr_ptr    (w_wr_ptr),
    .o_count     (count)
  );

  assign w_new = '{pc: in_pc, pc4: in_pc4, instr: in_instr, misalign: pc_misaligned(in_pc)};

  // Entries are cleared on reset so the idle head reads as PC 0 / PC+4 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[w_wr_ptr] <= w_new;
    end
  end

  assign w_head       = r_mem[w_rd_ptr];
  assign out_pc       = w_head.pc;
  assign out_pc4      = w_head.pc4;
  assign out_instr    = out_valid ? w_head.instr : RV_NOP;
  assign out_misalign = out_valid & w_head.misalign;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed vector table, stream/reset sequences,
// and a randomized run against a queue-based reference model.
module tb_fetch_decode_queue;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_pc4;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc4;
  logic [XLEN-1:0] out_instr;
  logic            out_misalign;
  logic [CW-1:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc4(in_pc4), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc4(out_pc4), .out_instr(out_instr),
    .out_misalign(out_misalign), .count(count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        flush, iv, ordy;
    logic [31:0] pc, instr;
    int          cnt;
    logic        ov, ir, mis;
    logic [31:0] epc, einstr;
  } vec_t;

  function automatic vec_t v(logic fl, logic iv, logic [31:0] pc, logic [31:0] instr,
                             logic ordy, int cnt, logic ov, logic ir, logic mis,
                             logic [31:0] epc, logic [31:0] einstr);
    vec_t r;
    r.flush = fl; r.iv = iv; r.pc = pc; r.instr = instr; r.ordy = ordy;
    r.cnt = cnt; r.ov = ov; r.ir = ir; r.mis = mis; r.epc = epc; r.einstr = einstr;
    return r;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ref_t;
  ref_t model_q[$];

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [31:0] instr, input logic ordy);
    flush = fl; in_valid = iv; in_pc = pc; in_pc4 = pc + 32'd4;
    in_instr = instr; out_ready = ordy;
  endtask

  // Checks outputs against the model (pre-edge view), then advances the model
  // as the coming clock edge will.
  task automatic check_model(input string tag);
    logic exp_valid, exp_ready, do_push, do_pop;
    exp_ready = (model_q.size() != DEPTH);
    exp_valid = (model_q.size() != 0) && !flush;
    check({tag, "_count"}, 64'(count), 64'(model_q.size()));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(exp_ready));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(exp_valid));
    if (exp_valid) begin
      check({tag, "_out_pc"}, 64'(out_pc), 64'(model_q[0].pc));
      check({tag, "_out_pc4"}, 64'(out_pc4), 64'(model_q[0].pc + 32'd4));
      check({tag, "_out_instr"}, 64'(out_instr), 64'(model_q[0].instr));
      check({tag, "_misalign"}, 64'(out_misalign), 64'(model_q[0].pc[1:0] != 2'b00));
    end else begin
      check({tag, "_nop"}, 64'(out_instr), 64'(NOP));
      check({tag, "_misalign0"}, 64'(out_misalign), 64'(0));
    end
    if (flush) begin
      model_q.delete();
    end else begin
      do_pop  = exp_valid && out_ready;
      do_push = in_valid && exp_ready;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back('{pc: in_pc, instr: in_instr});
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[$];

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    #12;
    check("reset_count", 64'(count), 64'(0));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_instr", 64'(out_instr), 64'(NOP));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_out_pc", 64'(out_pc), 64'(0));
    check("reset_out_pc4", 64'(out_pc4), 64'(0));
    check("reset_misalign", 64'(out_misalign), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // Each row: inputs applied this cycle and outputs expected before the edge.
    vecs.push_back(v(0,0,32'h00,32'h0,       0, 0,0,1,0, 32'h0, NOP));
    vecs.push_back(v(0,1,32'h00,32'h00500093,0, 0,0,1,0, 32'h0, NOP));
    vecs.push_back(v(0,0,32'h00,32'h0,       0, 1,1,1,0, 32'h0, 32'h00500093));
    vecs.push_back(v(0,1,32'h04,32'h00A00113,0, 1,1,1,0, 32'h0, 32'h00500093));
    vecs.push_back(v(0,1,32'h08,32'h00F00193,0, 2,1,0,0, 32'h0, 32'h00500093));
    vecs.push_back(v(0,0,32'h00,32'h0,       1, 2,1,0,0, 32'h0, 32'h00500093));
    vecs.push_back(v(0,0,32'h00,32'h0,       1, 1,1,1,0, 32'h4, 32'h00A00113));
    vecs.push_back(v(0,0,32'h00,32'h0,       1, 0,0,1,0, 32'h0, NOP));
    vecs.push_back(v(0,1,32'h10,32'h11111111,0, 0,0,1,0, 32'h0, NOP));
    vecs.push_back(v(0,1,32'h14,32'h22222222,0, 1,1,1,0, 32'h10, 32'h11111111));
    vecs.push_back(v(1,1,32'h40,32'h44444444,0, 2,0,0,0, 32'h0, NOP));
    vecs.push_back(v(0,0,32'h00,32'h0,       0, 0,0,1,0, 32'h0, NOP));
    vecs.push_back(v(0,1,32'h06,32'h66666666,0, 0,0,1,0, 32'h0, NOP));
    vecs.push_back(v(0,0,32'h00,32'h0,       0, 1,1,1,1, 32'h6, 32'h66666666));
    vecs.push_back(v(1,1,32'h50,32'h55555555,1, 1,0,1,0, 32'h0, NOP));
    vecs.push_back(v(0,0,32'h00,32'h0,       1, 0,0,1,0, 32'h0, NOP));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].flush, vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].ordy);
      #1;
      check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].cnt));
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].ir));
      check($sformatf("vec%0d_out_instr", i), 64'(out_instr), 64'(vecs[i].einstr));
      check($sformatf("vec%0d_misalign", i), 64'(out_misalign), 64'(vecs[i].mis));
      if (vecs[i].ov) begin
        check($sformatf("vec%0d_out_pc", i), 64'(out_pc), 64'(vecs[i].epc));
        check($sformatf("vec%0d_out_pc4", i), 64'(out_pc4), 64'(vecs[i].epc + 32'd4));
      end
    end

    // Steady stream: each word appears one cycle after capture, occupancy stays 1.
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      drive(0, k < 8, 32'(4 * k), 32'hA000_0000 + 32'(k), 1);
      #1;
      if (k == 0) begin
        check("stream_count0", 64'(count), 64'(0));
      end else begin
        check($sformatf("stream%0d_count", k), 64'(count), 64'(1));
        check($sformatf("stream%0d_valid", k), 64'(out_valid), 64'(1));
        check($sformatf("stream%0d_pc", k), 64'(out_pc), 64'(4 * (k - 1)));
        check($sformatf("stream%0d_instr", k), 64'(out_instr), 64'(32'hA000_0000 + 32'(k - 1)));
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    check("stream_drained", 64'(count), 64'(0));

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive($urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0,
            $urandom(), $urandom(), $urandom_range(0, 2) != 0);
      #1;
      check_model($sformatf("rnd%0d", n));
    end

    // Asynchronous reset between edges with two words buffered.
    @(negedge clk);
    drive(1, 0, 0, 0, 0);
    #1;
    check_model("pre_reset_flush");
    @(negedge clk);
    drive(0, 1, 32'h100, 32'h0000_0101, 0);
    #1;
    check_model("pre_reset0");
    @(negedge clk);
    drive(0, 1, 32'h104, 32'h0000_0202, 0);
    #1;
    check_model("pre_reset1");
    @(posedge clk);
    #2;
    drive(0, 0, 0, 0, 0);
    check("mid_before_reset_count", 64'(count), 64'(2));
    reset = 1'b1;
    #1;
    check("mid_reset_count", 64'(count), 64'(0));
    check("mid_reset_out_valid", 64'(out_valid), 64'(0));
    check("mid_reset_out_instr", 64'(out_instr), 64'(NOP));
    model_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_model("post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
